// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a store FIFO and a programmable baud divisor.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR     = 32'h80000010,
    parameter int          FIFO_DEPTH    = 8,
    parameter logic [15:0] DIVISOR_RESET = 16'd217
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_address_in,
    input  logic [31:0] mem_wdata_in,
    input  logic        mem_wenable_in,
    output logic [31:0] mem_rdata_out,
    output logic        tx,
    output logic        irq_empty
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [29:0] DATA_WORD   = BASE_ADDR[31:2];
    localparam logic [29:0] STATUS_WORD = BASE_ADDR[31:2] + 30'd1;
    localparam logic [29:0] DIV_WORD    = BASE_ADDR[31:2] + 30'd2;

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state;
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic [15:0]        divisor;
    logic [15:0]        eff_div;
    logic [15:0]        baud_div;
    logic [15:0]        baud_cnt;
    logic [7:0]         shift_reg;
    logic [2:0]         bit_idx;
`ifdef UART_TX_PARITY_EN
    logic               parity_bit;
`endif

    logic hit_data;
    logic hit_status;
    logic hit_div;
    logic full;
    logic empty;
    logic busy;
    logic push_req;
    logic push;
    logic pop;
    logic unused_bits;

    assign hit_data   = (mem_address_in[31:2] == DATA_WORD);
    assign hit_status = (mem_address_in[31:2] == STATUS_WORD);
    assign hit_div    = (mem_address_in[31:2] == DIV_WORD);

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign busy  = (state != S_IDLE);

    // A store to DATA while full is dropped even if the transmitter pops in the same cycle.
    assign push_req = mem_wenable_in && hit_data;
    assign push     = push_req && !full;
    assign pop      = (state == S_IDLE) && !empty;

    assign eff_div   = (divisor == 16'd0) ? 16'd1 : divisor;
    assign irq_empty = empty && (state == S_IDLE);

    assign unused_bits = ^{mem_wdata_in[31:16], mem_address_in[1:0]};

    always_comb begin
        mem_rdata_out = 32'd0;
        if (hit_status) begin
            mem_rdata_out = {19'd0, 5'(count), 3'd0, PARITY_EN, overflow, empty, full, busy};
        end else if (hit_div) begin
            mem_rdata_out = {16'd0, divisor};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_wdata_in[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            divisor  <= DIVISOR_RESET;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (mem_wenable_in && hit_status && mem_wdata_in[3]) begin
                overflow <= 1'b0;
            end
            if (mem_wenable_in && hit_div) begin
                divisor <= mem_wdata_in[15:0];
            end
        end
    end

    // Every phase (start, each data bit, parity, stop) lasts baud_div cycles; the divisor is
    // captured when a byte is popped so mid-frame DIVISOR writes only affect later frames.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            tx         <= 1'b1;
            shift_reg  <= 8'd0;
            bit_idx    <= 3'd0;
            baud_div   <= 16'd1;
            baud_cnt   <= 16'd0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift_reg  <= fifo_mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^fifo_mem[rd_ptr];
`endif
                        baud_div   <= eff_div;
                        baud_cnt   <= eff_div - 16'd1;
                        bit_idx    <= 3'd0;
                        tx         <= 1'b0;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= baud_div - 16'd1;
                        tx       <= shift_reg[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= baud_div - 16'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= S_PARITY;
`else
                            tx    <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            tx        <= shift_reg[1];
                            bit_idx   <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= baud_div - 16'd1;
                        tx       <= 1'b1;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    tx <= 1'b1;
                    if (baud_cnt == 16'd0) begin
                        state <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed and random register traffic checked cycle by cycle
// against a frame-level reference model of the FIFO and the serial line.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE       = 32'h80000010;
    localparam logic [31:0] A_DATA     = BASE;
    localparam logic [31:0] A_STATUS   = BASE + 32'd4;
    localparam logic [31:0] A_DIV      = BASE + 32'd8;
    localparam int          DEPTH      = 8;
`ifdef UART_TX_PARITY_EN
    localparam int          NB  = 11;
    localparam logic        PAR = 1'b1;
`else
    localparam int          NB  = 10;
    localparam logic        PAR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] mem_address_in;
    logic [31:0] mem_wdata_in;
    logic        mem_wenable_in;
    logic [31:0] mem_rdata_out;
    logic        tx;
    logic        irq_empty;

    int errors = 0;
    int checks = 0;

    uart_tx_mmio #(
        .BASE_ADDR(BASE),
        .FIFO_DEPTH(DEPTH),
        .DIVISOR_RESET(16'd217)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem_address_in(mem_address_in),
        .mem_wdata_in(mem_wdata_in),
        .mem_wenable_in(mem_wenable_in),
        .mem_rdata_out(mem_rdata_out),
        .tx(tx),
        .irq_empty(irq_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a byte queue plus the frame currently on the line, described by its
    // start cycle, latched divisor and byte; a frame occupies NB*D cycles and the line idles one cycle between frames.
    logic [7:0] q[$];
    logic       m_ovf    = 1'b0;
    logic [15:0] m_div   = 16'd217;
    longint     cyc      = 0;
    longint     fr_p     = 0;
    int         fr_d     = 1;
    logic [7:0] fr_byte  = 8'd0;
    bit         fr_active = 1'b0;
    bit         m_idle;
    int         m_size;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_ovf     = 1'b0;
            m_div     = 16'd217;
            fr_active = 1'b0;
        end else begin
            m_idle = !fr_active || (cyc >= fr_p + longint'(NB * fr_d));
            m_size = q.size();
            if (m_idle && m_size > 0) begin
                fr_byte   = q.pop_front();
                fr_d      = (m_div == 16'd0) ? 1 : int'(m_div);
                fr_p      = cyc + 1;
                fr_active = 1'b1;
            end
            if (mem_wenable_in) begin
                if (mem_address_in[31:2] == A_DATA[31:2]) begin
                    if (m_size == DEPTH) m_ovf = 1'b1;
                    else q.push_back(mem_wdata_in[7:0]);
                end else if (mem_address_in[31:2] == A_STATUS[31:2]) begin
                    if (mem_wdata_in[3]) m_ovf = 1'b0;
                end else if (mem_address_in[31:2] == A_DIV[31:2]) begin
                    m_div = mem_wdata_in[15:0];
                end
            end
            cyc = cyc + 1;
        end
    end

    function automatic logic exp_busy();
        return fr_active && (cyc < fr_p + longint'(NB * fr_d));
    endfunction

    function automatic logic exp_tx();
        longint j;
        int idx;
        if (!exp_busy()) return 1'b1;
        j   = cyc - fr_p;
        idx = int'(j / longint'(fr_d));
        if (idx == 0) return 1'b0;
        if (idx <= 8) return fr_byte[idx-1];
        if (NB == 11 && idx == 9) return ^fr_byte;
        return 1'b1;
    endfunction

    function automatic logic exp_irq();
        return (q.size() == 0) && !exp_busy();
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] addr);
        logic [4:0] cnt;
        cnt = 5'(q.size());
        if (addr[31:2] == A_STATUS[31:2])
            return {19'd0, cnt, 3'd0, PAR, m_ovf, (q.size() == 0), (q.size() == DEPTH), exp_busy()};
        if (addr[31:2] == A_DIV[31:2])
            return {16'd0, m_div};
        return 32'd0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        checkOutput("tx", {31'd0, tx}, {31'd0, exp_tx()});
        checkOutput("irq_empty", {31'd0, irq_empty}, {31'd0, exp_irq()});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        mem_address_in = addr;
        mem_wdata_in   = data;
        mem_wenable_in = 1'b1;
        tick();
        mem_wenable_in = 1'b0;
    endtask

    task automatic readReg(input string tag, input logic [31:0] addr);
        mem_wenable_in = 1'b0;
        mem_address_in = addr;
        #1;
        checkOutput(tag, mem_rdata_out, exp_read(addr));
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        while ((exp_busy() || q.size() != 0) && b > 0) begin
            tick();
            b--;
        end
        ticks(2);
    endtask

    logic [7:0] rb;

    initial begin
        reset          = 1'b1;
        mem_address_in = 32'd0;
        mem_wdata_in   = 32'd0;
        mem_wenable_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Reset state and address decode
        checkOutput("reset_tx", {31'd0, tx}, 32'd1);
        checkOutput("reset_irq", {31'd0, irq_empty}, 32'd1);
        readReg("reset_status", 32'h80000014);
        checkOutput("reset_status_const", mem_rdata_out, 32'h00000004 | {27'd0, PAR, 4'd0});
        readReg("reset_div", 32'h80000018);
        checkOutput("reset_div_const", mem_rdata_out, 32'h000000D9);
        readReg("div_alias", 32'h8000001B);
        readReg("data_reads_zero", A_DATA);
        readReg("outside_window", 32'h8000001C);
        readReg("below_window", 32'h8000000C);

        // Single frame 0x55 at D=4; upper DIVISOR bits are ignored
        applyStimulus(A_DIV, 32'hFFFF0004);
        readReg("div_upper_zero", A_DIV);
        applyStimulus(A_DATA, 32'h00000055);
        checkOutput("pre_start_tx", {31'd0, tx}, 32'd1);
        tick();
        checkOutput("start_latency", {31'd0, tx}, 32'd0);
        readReg("busy_mid_frame", A_STATUS);
        ticks(20);
        readReg("busy_late_frame", A_STATUS);
        drain(200);
        checkOutput("irq_after_stop", {31'd0, irq_empty}, 32'd1);

        // Overflow: FSM busy on a filler byte, then 9 stores in consecutive cycles
        applyStimulus(A_DIV, 32'd2);
        applyStimulus(A_DATA, 32'h000000C3);
        for (int i = 0; i <= 8; i++) applyStimulus(A_DATA, 32'(i));
        readReg("overflow_status", A_STATUS);
        checkOutput("peak_count", {27'd0, mem_rdata_out[12:8]}, 32'd8);
        checkOutput("overflow_set", {31'd0, mem_rdata_out[3]}, 32'd1);
        checkOutput("full_set", {31'd0, mem_rdata_out[1]}, 32'd1);
        applyStimulus(A_STATUS, 32'h00000008);
        readReg("overflow_clear", A_STATUS);
        checkOutput("overflow_cleared", {31'd0, mem_rdata_out[3]}, 32'd0);
        drain(600);

        // DIVISOR change mid-frame applies to the following frame only
        applyStimulus(A_DIV, 32'd3);
        applyStimulus(A_DATA, 32'h000000A5);
        ticks(5);
        applyStimulus(A_DIV, 32'd6);
        applyStimulus(A_DATA, 32'h0000003C);
        readReg("div_readback", A_DIV);
        drain(400);

        // Asynchronous reset during data bit 3 with three bytes queued
        applyStimulus(A_DIV, 32'd3);
        rb = 8'($urandom) & 8'hF7;
        applyStimulus(A_DATA, {24'd0, rb});
        for (int i = 0; i < 3; i++) applyStimulus(A_DATA, 32'($urandom_range(0, 255)));
        ticks(11);
        checkOutput("bit3_low_before_reset", {31'd0, tx}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("reset_async_tx", {31'd0, tx}, 32'd1);
        checkOutput("reset_async_irq", {31'd0, irq_empty}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        readReg("post_reset_status", A_STATUS);
        checkOutput("post_reset_count", {27'd0, mem_rdata_out[12:8]}, 32'd0);
        readReg("post_reset_div", A_DIV);
        checkOutput("post_reset_div_const", mem_rdata_out, 32'd217);
        ticks(40);

        // Random traffic, including divisor 0 which behaves as 1
        for (int r = 0; r < 6; r++) begin
            applyStimulus(A_DIV, 32'($urandom_range(0, 3)));
            for (int b = 0; b < int'($urandom_range(1, 4)); b++) begin
                applyStimulus(A_DATA, $urandom);
                ticks(int'($urandom_range(0, 2)));
                readReg("rand_status", A_STATUS);
            end
            readReg("rand_div", A_DIV);
            drain(600);
        end

`ifdef UART_TX_PARITY_EN
        applyStimulus(A_DIV, 32'd1);
        applyStimulus(A_DATA, 32'h00000007);
        readReg("parity_status", A_STATUS);
        checkOutput("parity_flag", {31'd0, mem_rdata_out[4]}, 32'd1);
        drain(100);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter. Acts as a responder on the CPU data port: address, write data, write enable in; combinational read data out.
- Sits beside RAM and the LED register in the SoC address decoder. The SoC ORs `mem_rdata_out` into the data-port read mux.
- Buffers CPU stores in a small FIFO and serialises each byte as 8N1 on the `tx` pin, LSB first.

Parameters:
- BASE_ADDR, 32'h80000010, word-aligned base of the 3-register window.
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, 2..16.
- DIVISOR_RESET, 16'd217, reset value of DIVISOR (25 MHz / 115200 baud).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- mem_address_in  in  32  CPU data address.
- mem_wdata_in  in  32  CPU store data.
- mem_wenable_in  in  1  CPU store strobe, sampled at posedge clk.
- mem_rdata_out  out  32  combinational read data; 0 when address not in window.
- tx  out  1  serial output, idle high.
- irq_empty  out  1  high while FIFO empty and FSM IDLE.

Behaviour:
- Decode compares `mem_address_in[31:2]` against `(BASE_ADDR+off)[31:2]`; bits [1:0] ignored. Reads have no side effects.
- Register map:
  - Offset 0x0 DATA: write pushes `wdata[7:0]`; reads as 0.
  - Offset 0x4 STATUS (R):
    - bit0 busy (FSM != IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - bits[12:8] FIFO count
    - other bits 0
  - Offset 0x4 STATUS (W): writing 1 to bit3 clears overflow; other bits ignored.
  - Offset 0x8 DIVISOR: R/W, bits[15:0]; upper bits read 0.
- Reset (async) values:
  - tx=1, FSM=IDLE, FIFO empty (count 0), overflow=0, DIVISOR=DIVISOR_RESET.
  - irq_empty=1, mem_rdata_out follows decode (combinational).
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
  - Push when full: byte dropped, overflow<=1. This applies even if a pop occurs the same cycle.
  - Push and pop in the same cycle when not full: count unchanged, both take effect.
- FSM states: IDLE, START, DATA, STOP (plus PARITY under option).
  - IDLE: if FIFO non-empty, pop the head into an 8-bit shift register and latch the effective divisor; next state START, tx<=0.
    - Latency: a DATA write at edge E into an empty FIFO with FSM idle drives tx low after edge E+1.
  - START: hold for D cycles, then go to DATA with tx<=shift[0].
  - DATA: each bit held D cycles; shift right; after bit 7 go to STOP, tx<=1.
  - STOP: hold D cycles, then return to IDLE.
  - Back-to-back: with the FIFO non-empty at STOP end, IDLE lasts exactly 1 cycle. Frame period = 10*D+1 cycles.
- Baud counter:
  - D = latched divisor; a value of 0 is treated as 1.
  - Counter reloads on every state or bit change.
  - A DIVISOR write mid-frame takes effect only at the next frame's IDLE->START.
- irq_empty = empty && FSM==IDLE, registered-free (combinational from state).
- Reset asserted mid-frame: tx returns high immediately (asynchronously); FIFO contents are discarded.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state between DATA and STOP transmits even parity (XOR of the 8 data bits), held D cycles. Frame = 11*D+1 cycles. STATUS bit4 reads 1.
- Undefined: no PARITY state; 8N1 only; STATUS bit4 reads 0.

Test Plan:
- Reset, DIVISOR left at default; read 0x80000014 -> 0x00000004 (empty); read 0x80000018 -> 0x000000D9; tx=1; irq_empty=1.
- Write DIVISOR=4, write DATA=0x55 -> tx low one cycle after the write edge. Bit sequence 0,1,0,1,0,1,0,1,0,1, each 4 cycles. busy=1 throughout; irq_empty=1 again after the stop bit.
- DIVISOR=2, write 9 bytes 0x00..0x08 in consecutive cycles with FSM busy on byte 0:
  - count peaks at 8; the 9th write sets overflow (STATUS bit3=1);
  - the transmitted stream contains bytes 0x00..0x07 except those already popped, and never 0x08;
  - write STATUS 0x8 -> overflow=0.
- DIVISOR=3, send 0xA5; write DIVISOR=6 during the DATA state -> current frame keeps 3-cycle bits; the next frame uses 6-cycle bits.
- Assert reset during bit 3 of a frame with 3 bytes queued -> tx=1 immediately. After release: count=0, no further start bits, DIVISOR=217.
- With UART_TX_PARITY_EN, DIVISOR=1, send 0x07 -> frame 0,1,1,1,0,0,0,0,0,1(parity),1(stop); STATUS bit4=1.
